// File: rtl/rst_wdog.sv
// Watchdog and software reset-request source driving the active-low erst input of
// the reset synchronizer; produces one clean, minimum-width, rate-limited pulse and a sticky cause.
module rst_wdog #(
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 50000,
  parameter int WARNLEN = 1000,
  parameter int PULSEW  = 8,
  parameter int HOLDOFF = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wd_en,
  input  logic       kick,
  input  logic       sw_req,
  input  logic       cause_clr,
  output logic       erst,
  output logic       warn,
  output logic       busy,
  output logic [1:0] cause
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIRE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [CNTW-1:0] TO_LD   = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] PW_LD   = CNTW'(PULSEW - 1);
  localparam logic [CNTW-1:0] HO_LD   = CNTW'(HOLDOFF - 1);
  localparam logic [CNTW-1:0] WARN_TH = CNTW'(WARNLEN);

  logic [1:0]      state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [1:0]      cause_set;
  logic            cnt_zero;

  function automatic logic [CNTW-1:0] cnt_dec(input logic [CNTW-1:0] v);
    return v - CNTW'(1);
  endfunction

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cause_set = 2'b00;
    case (state)
      IDLE: begin
        if (sw_req) begin
          state_n      = FIRE;
          cnt_n        = PW_LD;
          cause_set[1] = 1'b1;
        end else if (wd_en) begin
          state_n = RUN;
          cnt_n   = TO_LD;
        end
      end
      RUN: begin
        if (sw_req) begin
          state_n      = FIRE;
          cnt_n        = PW_LD;
          cause_set[1] = 1'b1;
          // An expiry coinciding with the request is still recorded as a timeout.
          cause_set[0] = cnt_zero && !kick;
        end else if (!wd_en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (kick) begin
          cnt_n = TO_LD;
        end else if (!cnt_zero) begin
          cnt_n = cnt_dec(cnt);
        end else begin
          state_n      = FIRE;
          cnt_n        = PW_LD;
          cause_set[0] = 1'b1;
        end
      end
      FIRE: begin
        if (cnt_zero) begin
          state_n = HOLD;
          cnt_n   = HO_LD;
        end else begin
          cnt_n = cnt_dec(cnt);
        end
      end
      default: begin
        // Requests and kicks arriving during holdoff are dropped, not queued.
        if (cnt_zero) begin
          state_n = wd_en ? RUN : IDLE;
          cnt_n   = wd_en ? TO_LD : '0;
        end else begin
          cnt_n = cnt_dec(cnt);
        end
      end
    endcase
  end

  // Outputs are registered from the next state so erst switches on the deciding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      erst  <= 1'b1;
      warn  <= 1'b0;
      busy  <= 1'b0;
      cause <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      erst  <= (state_n != FIRE);
      warn  <= (state_n == RUN) && (cnt_n < WARN_TH);
      busy  <= (state_n == FIRE) || (state_n == HOLD);
      cause <= (cause & ~{2{cause_clr}}) | cause_set;
    end
  end

endmodule

// File: tb/tb_rst_wdog.sv
// Directed bench for rst_wdog with TIMEOUT=20 WARNLEN=5 PULSEW=4 HOLDOFF=6.
module tb_rst_wdog;

  logic       clk = 1'b0;
  logic       rst, wd_en, kick, sw_req, cause_clr;
  logic       erst, warn, busy;
  logic [1:0] cause;
  int         checks = 0;
  int         errors = 0;

  rst_wdog #(.CNTW(16), .TIMEOUT(20), .WARNLEN(5), .PULSEW(4), .HOLDOFF(6)) dut (
    .clk(clk), .rst(rst), .wd_en(wd_en), .kick(kick), .sw_req(sw_req),
    .cause_clr(cause_clr), .erst(erst), .warn(warn), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    rst = 1'b1; wd_en = en; kick = 1'b0; sw_req = 1'b0; cause_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wd_en = 1'b1; kick = 1'b0; sw_req = 1'b0; cause_clr = 1'b0;
    tick(); tick();
    checks++; if (erst !== 1'b1) begin errors++; $display("FAIL reset_erst got %b exp 1", erst); end
    checks++; if (warn !== 1'b0) begin errors++; $display("FAIL reset_warn got %b exp 0", warn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", cause); end
  endtask

  task automatic test_timeout();
    logic ee, eb, ew;
    int lows;
    lows = 0;
    do_reset(1'b1);
    tick();  // IDLE -> RUN
    checks++; if (warn !== 1'b0) begin errors++; $display("FAIL to_warn_e0 got %b exp 0", warn); end
    for (int k = 1; k <= 35; k++) begin
      tick();
      ee = !(k >= 20 && k <= 23);
      eb = (k >= 20 && k <= 29);
      ew = (k >= 15 && k <= 19);
      if (!erst) lows++;
      checks++; if (erst !== ee) begin errors++; $display("FAIL to_erst k=%0d got %b exp %b", k, erst, ee); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL to_busy k=%0d got %b exp %b", k, busy, eb); end
      checks++; if (warn !== ew) begin errors++; $display("FAIL to_warn k=%0d got %b exp %b", k, warn, ew); end
    end
    checks++; if (lows != 4) begin errors++; $display("FAIL to_pulse_width got %0d exp 4", lows); end
    checks++; if (cause !== 2'b01) begin errors++; $display("FAIL to_cause got %b exp 01", cause); end
  endtask

  task automatic test_kicking();
    int lows, warns;
    lows = 0; warns = 0;
    do_reset(1'b1);
    tick();
    for (int i = 1; i <= 200; i++) begin
      kick = ((i % 15) == 0);
      tick();
      kick = 1'b0;
      if (!erst) lows++;
      if (warn) warns++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL kick_erst_low got %0d exp 0", lows); end
    checks++; if (warns != 0) begin errors++; $display("FAIL kick_warn_high got %0d exp 0", warns); end
    // Kick on the cnt==0 cycle.
    do_reset(1'b1);
    tick();
    for (int i = 1; i <= 19; i++) tick();
    checks++; if (warn !== 1'b1) begin errors++; $display("FAIL kick0_warn_before got %b exp 1", warn); end
    kick = 1'b1;
    tick();
    kick = 1'b0;
    checks++; if (erst !== 1'b1) begin errors++; $display("FAIL kick0_erst got %b exp 1", erst); end
    checks++; if (warn !== 1'b0) begin errors++; $display("FAIL kick0_warn got %b exp 0", warn); end
    for (int i = 1; i <= 19; i++) tick();
    checks++; if (erst !== 1'b1) begin errors++; $display("FAIL kick0_reload_early got %b exp 1", erst); end
    tick();
    checks++; if (erst !== 1'b0) begin errors++; $display("FAIL kick0_reload_fire got %b exp 0", erst); end
  endtask

  task automatic test_sw_req();
    int lows;
    lows = 0;
    do_reset(1'b0);
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle_busy got %b exp 0", busy); end
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    lows = erst ? 0 : 1;
    checks++; if (erst !== 1'b0) begin errors++; $display("FAIL sw_erst_edge got %b exp 0", erst); end
    checks++; if (cause !== 2'b10) begin errors++; $display("FAIL sw_cause got %b exp 10", cause); end
    for (int j = 1; j <= 12; j++) begin
      sw_req = (j == 6);
      tick();
      sw_req = 1'b0;
      if (!erst) lows++;
      if (j == 9) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_hold_busy got %b exp 1", busy); end
      end
      if (j == 10) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_hold_exit got %b exp 0", busy); end
      end
    end
    checks++; if (lows != 4) begin errors++; $display("FAIL sw_pulse_width got %0d exp 4", lows); end
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL sw_cause_clr got %b exp 00", cause); end
    // Set and clear together: set wins.
    sw_req = 1'b1; cause_clr = 1'b1;
    tick();
    sw_req = 1'b0; cause_clr = 1'b0;
    checks++; if (cause !== 2'b10) begin errors++; $display("FAIL sw_set_wins got %b exp 10", cause); end
  endtask

  task automatic test_simultaneous();
    int lows;
    lows = 0;
    do_reset(1'b1);
    tick();
    for (int i = 1; i <= 19; i++) tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    if (!erst) lows++;
    checks++; if (cause !== 2'b11) begin errors++; $display("FAIL sim_cause got %b exp 11", cause); end
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (!erst) lows++;
    end
    checks++; if (lows != 4) begin errors++; $display("FAIL sim_pulse_width got %0d exp 4", lows); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick();
    sw_req = 1'b1;
    tick();            // first FIRE cycle
    sw_req = 1'b0;
    tick();            // second FIRE cycle
    checks++; if (erst !== 1'b0) begin errors++; $display("FAIL mid_in_fire got %b exp 0", erst); end
    rst = 1'b1;
    tick();
    checks++; if (erst !== 1'b1) begin errors++; $display("FAIL mid_erst got %b exp 1", erst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL mid_cause got %b exp 00", cause); end
    rst = 1'b0; wd_en = 1'b1;
    tick();            // IDLE -> RUN
    for (int i = 1; i <= 19; i++) tick();
    checks++; if (erst !== 1'b1) begin errors++; $display("FAIL mid_timeout_early got %b exp 1", erst); end
    tick();
    checks++; if (erst !== 1'b0) begin errors++; $display("FAIL mid_timeout_fire got %b exp 0", erst); end
  endtask

  initial begin
    rst = 1'b1; wd_en = 1'b0; kick = 1'b0; sw_req = 1'b0; cause_clr = 1'b0;
    test_reset();
    test_timeout();
    test_kicking();
    test_sw_req();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
